// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
//
// Multi-cycle word adder front end. A WIDTH-bit addition is split into 4-bit
// slices that go one at a time through an external registered 4-bit
// carry-lookahead stage. Each slice's carry-out becomes the next slice's
// carry-in, and the returned nibble sums are assembled into the output word.
//
// Parameters
//   WIDTH      operand width in bits (multiple of 4, minimum 8)
//   STAGE_LAT  register latency of the downstream 4-bit adder stage
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready     operand request handshake (ready only in IDLE)
//   in_a, in_b, in_cin    operands and carry-in, latched on accept
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     assembled sum and final carry-out
//   out_ovf               two's-complement overflow (OVERFLOW_FLAG_EN only)
//   nib_a, nib_b, nib_cin slice operands and carry to the adder stage
//   nib_sum, nib_cout     registered result from the adder stage
//   busy                  high while in RUN or DONE
//
// Build option
//   OVERFLOW_FLAG_EN      when defined, adds the out_ovf output

module cla_nibble_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef OVERFLOW_FLAG_EN
  output logic             out_ovf,
`endif
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_sum,
  input  logic             nib_cout,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CNT_W = (STAGE_LAT > 0) ? $clog2(STAGE_LAT + 1) : 1;
  localparam int unsigned SEL_W = $clog2(WIDTH);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGE_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // Bit offsets of the slice being captured and the slice driven next.
  logic [IDX_W-1:0] idx_nxt;
  logic [SEL_W-1:0] cap_lsb;
  logic [SEL_W-1:0] nxt_lsb;

  assign idx_nxt = idx + IDX_W'(1);
  assign cap_lsb = SEL_W'({idx, 2'b00});
  assign nxt_lsb = SEL_W'({idx_nxt, 2'b00});

  // Sequencer: accept, step slices through the adder stage, hand off result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      out_ovf   <= 1'b0;
`endif
      nib_a     <= '0;
      nib_b     <= '0;
      nib_cin   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            nib_a    <= in_a[3:0];
            nib_b    <= in_b[3:0];
            nib_cin  <= in_cin;
            idx      <= '0;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Stage result for the current slice is valid on this edge.
            out_sum[cap_lsb +: 4] <= nib_sum;
            if (idx != LAST_IDX) begin
              nib_a   <= a_reg[nxt_lsb +: 4];
              nib_b   <= b_reg[nxt_lsb +: 4];
              nib_cin <= nib_cout;
              cnt     <= CNT_LOAD;
              idx     <= idx_nxt;
            end else begin
              out_cout  <= nib_cout;
`ifdef OVERFLOW_FLAG_EN
              // Same-sign operands whose sum sign differs.
              out_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (nib_sum[3] != a_reg[WIDTH-1]);
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Testbench for cla_nibble_sequencer with a behavioural model of the
// registered 4-bit adder stage (two register stages, sharing clk/rst).

module tb_cla_nibble_sequencer;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned STAGE_LAT = 2;
  localparam int          BUDGET    = 40;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef OVERFLOW_FLAG_EN
  logic             out_ovf;
`endif
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             nib_cin;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             busy;

  int n_checks;
  int n_fail;

  cla_nibble_sequencer #(.WIDTH(WIDTH), .STAGE_LAT(STAGE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef OVERFLOW_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .nib_a     (nib_a),
    .nib_b     (nib_b),
    .nib_cin   (nib_cin),
    .nib_sum   (nib_sum),
    .nib_cout  (nib_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream adder stage model: two register stages of latency.
  logic [4:0] stg1;
  logic [4:0] stg2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stg1 <= '0;
      stg2 <= '0;
    end else begin
      stg1 <= 5'(nib_a) + 5'(nib_b) + 5'(nib_cin);
      stg2 <= stg1;
    end
  end
  assign nib_sum  = stg2[3:0];
  assign nib_cout = stg2[4];

  // Present a request for exactly one accepting edge (called at posedge+1).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid is seen (BUDGET on timeout).
  task automatic wait_valid(output int cyc);
    cyc = BUDGET;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    n_checks++; if ({nib_a, nib_b, nib_cin} !== 9'h000) begin n_fail++; $display("FAIL reset_nib got %h/%h/%b want 0/0/0", nib_a, nib_b, nib_cin); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_add();
    int cyc;
    send(16'h1234, 16'h4321, 1'b0);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_accept got rdy=%b busy=%b want 0/1", in_ready, busy); end
    n_checks++; if ({nib_a, nib_b, nib_cin} !== {4'h4, 4'h1, 1'b0}) begin n_fail++; $display("FAIL basic_slice0 got %h/%h/%b want 4/1/0", nib_a, nib_b, nib_cin); end
    wait_valid(cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL basic_latency got %0d want 12", cyc); end
    n_checks++; if (out_sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum got %h want 5555", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %b want 0", out_cout); end
    release_result();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_release got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_carry_chain();
    int cyc;
    cyc = 0;
    send(16'hFFFF, 16'h0001, 1'b0);
    n_checks++; if (nib_cin !== 1'b0) begin n_fail++; $display("FAIL chain_cin0 got %b want 0", nib_cin); end
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (i == 3 || i == 6 || i == 9) begin
        n_checks++; if (nib_cin !== 1'b1 || nib_a !== 4'hF || nib_b !== 4'h0) begin n_fail++; $display("FAIL chain_slice_at_%0d got a=%h b=%h cin=%b want F/0/1", i, nib_a, nib_b, nib_cin); end
      end
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL chain_latency got %0d want 12", cyc); end
    n_checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin n_fail++; $display("FAIL chain_result got %h c=%b want 0000 c=1", out_sum, out_cout); end
    release_result();
  endtask

  task automatic test_hold_and_ignore();
    int cyc;
    send(16'h00FF, 16'h0000, 1'b1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL hold_latency got %0d want 12", cyc); end
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'h0100 || out_cout !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_cycle_%0d got v=%b sum=%h c=%b rdy=%b want 1/0100/0/0", i, out_valid, out_sum, out_cout, in_ready); end
      n_checks++; if (nib_a !== 4'h0 || nib_b !== 4'h0) begin n_fail++; $display("FAIL hold_nib_%0d got %h/%h want 0/0", i, nib_a, nib_b); end
    end
    in_valid = 1'b0;
    release_result();
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ignored got busy=%b rdy=%b v=%b want 0/1/0", busy, in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    send(16'h1234, 16'h1111, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (out_sum !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_async got sum=%h v=%b busy=%b rdy=%b want 0000/0/0/1", out_sum, out_valid, busy, in_ready); end
    n_checks++; if ({nib_a, nib_b, nib_cin} !== 9'h000) begin n_fail++; $display("FAIL midrst_nib got %h/%h/%b want 0/0/0", nib_a, nib_b, nib_cin); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got rdy=%b busy=%b want 1/0", in_ready, busy); end
    send(16'hAAAA, 16'h5555, 1'b0);
    wait_valid(cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL midrst_latency got %0d want 12", cyc); end
    n_checks++; if (out_sum !== 16'hFFFF || out_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_result got %h c=%b want FFFF c=0", out_sum, out_cout); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    send(16'h0001, 16'h0001, 1'b0);
    wait_valid(cyc);
    n_checks++; if (cyc !== 12 || out_sum !== 16'h0002) begin n_fail++; $display("FAIL b2b_first got cyc=%0d sum=%h want 12/0002", cyc, out_sum); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_one_cycle_done got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    send(16'h0F0F, 16'h0101, 1'b1);
    wait_valid(cyc);
    n_checks++; if (cyc !== 12 || out_sum !== 16'h1011 || out_cout !== 1'b0) begin n_fail++; $display("FAIL b2b_second got cyc=%0d sum=%h c=%b want 12/1011/0", cyc, out_sum, out_cout); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow();
    int cyc;
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_valid(cyc);
    n_checks++; if (out_sum !== 16'h8000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos got %h c=%b o=%b want 8000/0/1", out_sum, out_cout, out_ovf); end
    release_result();
    send(16'h8000, 16'hFFFF, 1'b0);
    wait_valid(cyc);
    n_checks++; if (out_sum !== 16'h7FFF || out_cout !== 1'b1 || out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_neg got %h c=%b o=%b want 7FFF/1/1", out_sum, out_cout, out_ovf); end
    release_result();
    send(16'h0001, 16'h0001, 1'b0);
    wait_valid(cyc);
    n_checks++; if (out_sum !== 16'h0002 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none got %h o=%b want 0002/0", out_sum, out_ovf); end
    release_result();
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_hold_and_ignore();
    test_reset_mid_run();
    test_back_to_back();
`ifdef OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
